tx_param_ctrl: RTL and testbench

Parameter and run-control stage placed directly upstream of the HFSWR transmitter. It holds host-written shadow copies of the waveform parameters (phase increment, period, PRT, code, digit count, bit time) and validates them. It commits them atomically to the active outputs that drive the transmitter, and it generates the transmitter `start` level. In-flight parameter changes and stop requests are deferred to the next sincronismo rising edge, so a pulse in progress is never altered.

---
 rtl/tx_param_ctrl.sv | 170 +++++++++++++++++
 tb/tb_tx_param_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_param_ctrl.sv
// Transmitter parameter/run-control stage: host-written shadow registers, validated
// atomic commit to the active set, and the transmitter start level deferred to sinc edges.
module tx_param_ctrl #(
  parameter int ADDR_W  = 3,
  parameter int MAX_DIG = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data,
  input  logic              sinc,
  output logic              start,
  output logic [31:0]       phase,
  output logic [31:0]       period,
  output logic [31:0]       prt,
  output logic [31:0]       codigo,
  output logic [31:0]       num_dig,
  output logic [31:0]       t_b,
  output logic              pending,
  output logic              cfg_err
);

  // Host port: wr_en is a single-cycle strobe with no backpressure; every strobed
  // write is taken on the rising edge it is sampled at. Reads always return, one cycle later.

  localparam int DIG_W  = $clog2(MAX_DIG + 1);
  localparam int PROD_W = 32 + DIG_W;

  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(6);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(7);

  // Slot order: phase, period, prt, codigo, num_dig, t_b (matches the address map).
  localparam logic [31:0] RST_VAL [6] = '{32'h010AAAAA, 32'd25000, 32'd2500000,
                                          32'h00001F35, 32'd13, 32'd1923};

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_RUN   = 2'b10,
    S_DRAIN = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic        sinc_q;
  logic        pending_q, pending_d;
  logic        cfg_err_q, cfg_err_d;
  logic [31:0] sh_q  [6];
  logic [31:0] sh_d  [6];
  logic [31:0] act_q [6];
  logic [31:0] act_d [6];
  logic [31:0] rd_q, rd_d;

  logic ctrl_wr, run_p, commit_p, stop_p, errclr_p;
  logic sedge, sh_ok, act_ok;
  logic commit_now, copy, commit_err, run_err;

  function automatic logic set_ok(input logic [31:0] ph, input logic [31:0] per,
                                  input logic [31:0] pr, input logic [31:0] nd,
                                  input logic [31:0] tb);
    logic [PROD_W-1:0] prod;
    // Only the low DIG_W bits of nd matter once nd <= MAX_DIG is known to hold.
    prod = {{DIG_W{1'b0}}, tb} * {{32{1'b0}}, nd[DIG_W-1:0]};
    return (ph != '0) && (nd != '0) && (nd <= 32'(MAX_DIG)) && (tb != '0) &&
           (prod <= {{DIG_W{1'b0}}, per}) && (per < pr);
  endfunction

  always_comb begin
    ctrl_wr  = wr_en && (wr_addr == A_CTRL);
    run_p    = ctrl_wr && wr_data[0];
    commit_p = ctrl_wr && wr_data[1];
    stop_p   = ctrl_wr && wr_data[2];
    errclr_p = ctrl_wr && wr_data[3];
    sedge    = sinc && !sinc_q;
    sh_ok    = set_ok(sh_q[0], sh_q[1], sh_q[2], sh_q[4], sh_q[5]);
    act_ok   = set_ok(act_q[0], act_q[1], act_q[2], act_q[4], act_q[5]);
  end

  always_comb begin
    for (int k = 0; k < 6; k++) begin
      sh_d[k] = sh_q[k];
      if (wr_en && (wr_addr == ADDR_W'(k))) sh_d[k] = wr_data;
    end
  end

  // Outside IDLE a commit only arms; the copy happens on the next sinc edge.
  always_comb begin
    commit_now = (state_q == S_IDLE) ? commit_p : (pending_q && sedge);
    copy       = commit_now && sh_ok;
    commit_err = commit_now && !sh_ok;
    act_d      = act_q;
    if (copy) act_d = sh_q;
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    run_err   = 1'b0;
    if (state_q != S_IDLE) begin
      if (pending_q && sedge) pending_d = 1'b0;
      else if (commit_p)      pending_d = 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        // A same-write COMMIT lands first, so RUN validates the set being committed.
        if (run_p) begin
          if (copy || act_ok) state_d = S_ARMED;
          else                run_err = 1'b1;
        end
      end
      S_ARMED: state_d = S_RUN;
      S_RUN: begin
        if (stop_p) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (sedge) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    cfg_err_d = cfg_err_q;
    if (run_err || commit_err) cfg_err_d = 1'b1;
    else if (errclr_p)         cfg_err_d = 1'b0;
  end

  always_comb begin
    rd_d = '0;
    for (int k = 0; k < 6; k++) begin
      if (rd_addr == ADDR_W'(k)) rd_d = sh_q[k];
    end
    if (rd_addr == A_STATUS) rd_d = {28'b0, cfg_err_q, pending_q, state_q};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      sinc_q    <= 1'b0;
      pending_q <= 1'b0;
      cfg_err_q <= 1'b0;
      rd_q      <= '0;
      for (int k = 0; k < 6; k++) begin
        sh_q[k]  <= RST_VAL[k];
        act_q[k] <= RST_VAL[k];
      end
    end else begin
      state_q   <= state_d;
      sinc_q    <= sinc;
      pending_q <= pending_d;
      cfg_err_q <= cfg_err_d;
      rd_q      <= rd_d;
      for (int k = 0; k < 6; k++) begin
        sh_q[k]  <= sh_d[k];
        act_q[k] <= act_d[k];
      end
    end
  end

  assign start   = state_q[1];
  assign phase   = act_q[0];
  assign period  = act_q[1];
  assign prt     = act_q[2];
  assign codigo  = act_q[3];
  assign num_dig = act_q[4];
  assign t_b     = act_q[5];
  assign pending = pending_q;
  assign cfg_err = cfg_err_q;
  assign rd_data = rd_q;

endmodule

// File: tb/tb_tx_param_ctrl.sv
// Self-checking bench for tx_param_ctrl: directed scenarios plus randomized parameter
// sets checked against a transaction-level model of shadow/active/error behaviour.
module tb_tx_param_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [2:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic        sinc = 1'b0;
  logic        start, pending, cfg_err;
  logic [31:0] phase, period, prt, codigo, num_dig, t_b;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] exp_q[$];
  logic [31:0] DEF [6] = '{32'h010AAAAA, 32'd25000, 32'd2500000, 32'h00001F35, 32'd13, 32'd1923};
  logic [31:0] m_sh  [6];
  logic [31:0] m_act [6];
  bit          m_err;

  tx_param_ctrl #(.ADDR_W(3), .MAX_DIG(32)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .sinc(sinc), .start(start),
    .phase(phase), .period(period), .prt(prt), .codigo(codigo),
    .num_dig(num_dig), .t_b(t_b), .pending(pending), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit ref_valid(longint unsigned ph, longint unsigned per,
                                   longint unsigned pr, longint unsigned nd,
                                   longint unsigned tb);
    if (ph == 0 || tb == 0) return 0;
    if (nd < 1 || nd > 32) return 0;
    if (nd * tb > per) return 0;
    return per < pr;
  endfunction

  task automatic model_commit();
    if (ref_valid(m_sh[0], m_sh[1], m_sh[2], m_sh[4], m_sh[5])) begin
      for (int k = 0; k < 6; k++) m_act[k] = m_sh[k];
    end else begin
      m_err = 1;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 6; k++) begin
      m_sh[k] = DEF[k];
      m_act[k] = DEF[k];
    end
    m_err = 0;
  endtask

  function automatic logic [31:0] act_out(int k);
    case (k)
      0: return phase;
      1: return period;
      2: return prt;
      3: return codigo;
      4: return num_dig;
      default: return t_b;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [2:0] a, logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc(1);
    wr_en = 1'b0;
    if (a < 3'd6) m_sh[a] = d;
  endtask

  task automatic ctrl(logic [3:0] bits);
    wr(3'd6, {28'b0, bits});
  endtask

  task automatic rd(logic [2:0] a, output logic [31:0] v);
    rd_addr = a;
    cyc(1);
    v = rd_data;
  endtask

  task automatic sinc_pulse();
    sinc = 1'b1; cyc(1);
    sinc = 1'b0; cyc(1);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] v, e;
    rst = 1'b0; model_reset();
    cyc(3);
    rst = 1'b1;
    cyc(2);
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), v);
      e = (a < 6) ? m_sh[a] : 32'd0;
      total_cnt++;
      if (v !== e) $display("FAIL reset_read[%0d]: got %h want %h", a, v, e); else pass_cnt++;
    end
    for (int k = 0; k < 6; k++) begin
      total_cnt++;
      if (act_out(k) !== DEF[k]) $display("FAIL reset_active[%0d]: got %h want %h", k, act_out(k), DEF[k]);
      else pass_cnt++;
    end
    total_cnt++;
    if ({start, pending, cfg_err} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {start, pending, cfg_err});
    else pass_cnt++;
  endtask

  task automatic test_run_stop();
    logic [31:0] v;
    ctrl(4'b0001);
    total_cnt++;
    if (start !== 1'b0) $display("FAIL armed_start: got %b want 0", start); else pass_cnt++;
    rd(3'd7, v);
    total_cnt++;
    if (v !== 32'd1) $display("FAIL armed_status: got %h want 1", v); else pass_cnt++;
    total_cnt++;
    if (start !== 1'b1) $display("FAIL run_start: got %b want 1", start); else pass_cnt++;
    cyc(3);
    ctrl(4'b0100);
    rd(3'd7, v);
    total_cnt++;
    if (v !== 32'd3 || start !== 1'b1) $display("FAIL drain_status: got %h/%b want 3/1", v, start); else pass_cnt++;
    cyc(2);
    sinc = 1'b1; cyc(1);
    total_cnt++;
    if (start !== 1'b0) $display("FAIL stop_at_sedge: got %b want 0", start); else pass_cnt++;
    sinc = 1'b0;
    rd(3'd7, v);
    total_cnt++;
    if (v !== 32'd0) $display("FAIL idle_status: got %h want 0", v); else pass_cnt++;
  endtask

  task automatic test_deferred_commit();
    ctrl(4'b0001); cyc(1);
    wr(3'd0, 32'h02155555);
    ctrl(4'b0010);
    cyc(3);
    total_cnt++;
    if (pending !== 1'b1 || phase !== m_act[0])
      $display("FAIL deferred_hold: got pend=%b phase=%h want 1/%h", pending, phase, m_act[0]);
    else pass_cnt++;
    sinc = 1'b1; model_commit(); cyc(1);
    total_cnt++;
    if (pending !== 1'b0 || phase !== m_act[0] || m_act[0] !== 32'h02155555)
      $display("FAIL deferred_apply: got pend=%b phase=%h want 0/%h", pending, phase, m_act[0]);
    else pass_cnt++;
    sinc = 1'b0; cyc(1);
    ctrl(4'b0100); sinc_pulse();
    total_cnt++;
    if (start !== 1'b0) $display("FAIL deferred_stop: got %b want 0", start); else pass_cnt++;
  endtask

  task automatic test_invalid_commit();
    wr(3'd4, 32'd33);
    ctrl(4'b0010); model_commit();
    total_cnt++;
    if (cfg_err !== m_err || num_dig !== m_act[4])
      $display("FAIL ndig_reject: got err=%b nd=%0d want %b/%0d", cfg_err, num_dig, m_err, m_act[4]);
    else pass_cnt++;
    // ERR_CLR together with a fresh error: error must stick
    ctrl(4'b1010); model_commit();
    total_cnt++;
    if (cfg_err !== 1'b1) $display("FAIL err_wins: got %b want 1", cfg_err); else pass_cnt++;
    ctrl(4'b1000); m_err = 0;
    total_cnt++;
    if (cfg_err !== 1'b0) $display("FAIL err_clr: got %b want 0", cfg_err); else pass_cnt++;
    wr(3'd4, 32'd13);
  endtask

  task automatic test_product_reject();
    ctrl(4'b0001); cyc(1);
    wr(3'd5, 32'd2000);
    ctrl(4'b0010);
    total_cnt++;
    if (pending !== 1'b1) $display("FAIL prod_pending: got %b want 1", pending); else pass_cnt++;
    sinc = 1'b1; model_commit(); cyc(1);
    total_cnt++;
    if (cfg_err !== m_err || pending !== 1'b0 || start !== 1'b1 || t_b !== m_act[5])
      $display("FAIL prod_reject: got err=%b pend=%b start=%b tb=%0d want %b/0/1/%0d",
               cfg_err, pending, start, t_b, m_err, m_act[5]);
    else pass_cnt++;
    sinc = 1'b0; cyc(1);
    wr(3'd5, 32'd1923);
    ctrl(4'b1000); m_err = 0;
    ctrl(4'b0100); sinc_pulse();
  endtask

  task automatic test_stop_with_pending();
    logic [31:0] c1, c2, c3;
    c1 = $urandom; c2 = $urandom; c3 = ~c2;
    ctrl(4'b0001); cyc(1);
    wr(3'd3, c1);
    ctrl(4'b0010);
    wr(3'd3, c2);
    ctrl(4'b0010);
    ctrl(4'b0100);
    // shadow write lands in the sedge cycle itself: copy must take c2
    sinc = 1'b1; model_commit();
    wr(3'd3, c3);
    sinc = 1'b0;
    total_cnt++;
    if (codigo !== m_act[3] || start !== 1'b0 || pending !== 1'b0)
      $display("FAIL stop_pending: got code=%h start=%b pend=%b want %h/0/0", codigo, start, pending, m_act[3]);
    else pass_cnt++;
    cyc(1);
  endtask

  task automatic test_run_commit();
    logic [31:0] v;
    wr(3'd1, 32'd30000);
    wr(3'd4, 32'd15);
    wr(3'd5, 32'd2000);
    ctrl(4'b0011); model_commit();
    total_cnt++;
    if (period !== m_act[1] || t_b !== m_act[5] || cfg_err !== m_err || start !== 1'b0)
      $display("FAIL commit_run: got per=%0d tb=%0d err=%b start=%b want %0d/%0d/%b/0",
               period, t_b, cfg_err, start, m_act[1], m_act[5], m_err);
    else pass_cnt++;
    cyc(1);
    ctrl(4'b0101);
    rd(3'd7, v);
    total_cnt++;
    if (v !== 32'd3 || start !== 1'b1) $display("FAIL stop_wins: got %h/%b want 3/1", v, start); else pass_cnt++;
    sinc_pulse();
    ctrl(4'b0101);
    rd(3'd7, v);
    total_cnt++;
    if (v !== 32'd1) $display("FAIL run_wins_idle: got %h want 1", v); else pass_cnt++;
    // STOP coinciding with a sinc edge: that edge must not end the drain
    sinc = 1'b1; ctrl(4'b0100);
    sinc = 1'b0; cyc(2);
    total_cnt++;
    if (start !== 1'b1) $display("FAIL stop_same_sedge: got %b want 1", start); else pass_cnt++;
    sinc_pulse();
    total_cnt++;
    if (start !== 1'b0) $display("FAIL drain_end: got %b want 0", start); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [31:0] v, e;
    int unsigned ph, nd, per, tb, pr;
    for (int it = 0; it < 24; it++) begin
      ph  = ($urandom_range(0, 7) == 0) ? 0 : $urandom;
      nd  = $urandom_range(0, 34);
      per = $urandom_range(1000, 300000);
      tb  = (nd != 0) ? per / nd + $urandom_range(0, 2) - 1 : $urandom_range(0, 100);
      if ($urandom_range(0, 9) == 0) tb = 0;
      case ($urandom_range(0, 3))
        0: pr = per;
        1: pr = per + 1;
        2: pr = per - 1;
        default: pr = $urandom;
      endcase
      wr(3'd0, ph); wr(3'd1, per); wr(3'd2, pr);
      wr(3'd3, $urandom); wr(3'd4, nd); wr(3'd5, tb);
      for (int r = 0; r < 2; r++) begin
        int a;
        a = $urandom_range(0, 7);
        e = (a < 6) ? m_sh[a] : 32'd0;
        exp_q.push_back(e);
        rd(3'(a), v);
        e = exp_q.pop_front();
        total_cnt++;
        if (v !== e) $display("FAIL rand_read[%0d] a=%0d: got %h want %h", it, a, v, e); else pass_cnt++;
      end
      ctrl(4'b0010); model_commit();
      for (int k = 0; k < 6; k++) begin
        total_cnt++;
        if (act_out(k) !== m_act[k]) $display("FAIL rand_active[%0d][%0d]: got %h want %h", it, k, act_out(k), m_act[k]);
        else pass_cnt++;
      end
      total_cnt++;
      if (cfg_err !== m_err) $display("FAIL rand_err[%0d]: got %b want %b", it, cfg_err, m_err); else pass_cnt++;
      ctrl(4'b1000); m_err = 0;
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] v;
    ctrl(4'b0001); cyc(2);
    total_cnt++;
    if (start !== 1'b1) $display("FAIL pre_reset_run: got %b want 1", start); else pass_cnt++;
    #2 rst = 1'b0; model_reset();
    #1;
    total_cnt++;
    if ({start, pending, cfg_err} !== 3'b000 || rd_data !== 32'd0)
      $display("FAIL async_flags: got %b rd=%h want 000/0", {start, pending, cfg_err}, rd_data);
    else pass_cnt++;
    for (int k = 0; k < 6; k++) begin
      total_cnt++;
      if (act_out(k) !== m_act[k]) $display("FAIL async_active[%0d]: got %h want %h", k, act_out(k), m_act[k]);
      else pass_cnt++;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    cyc(1);
    rd(3'd7, v);
    total_cnt++;
    if (v !== 32'd0) $display("FAIL post_reset_status: got %h want 0", v); else pass_cnt++;
    rd(3'd0, v);
    total_cnt++;
    if (v !== m_sh[0]) $display("FAIL post_reset_shadow: got %h want %h", v, m_sh[0]); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_run_stop();
    test_deferred_commit();
    test_invalid_commit();
    test_product_reject();
    test_stop_with_pending();
    test_run_commit();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
